data_mem: RTL and testbench

//  Data memory for the RV32I core: byte-addressed, word-organised RAM with byte/half/word loads and stores.

---
 rtl/data_mem_pkg.sv | 8 +
 rtl/data_mem_align.sv | 29 ++
 rtl/data_mem.sv | 91 +++++++++
 tb/tb_data_mem.sv | 96 +++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM states, access size codes and sign-select bit for data_mem.
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE, RD_BUF, READ, WRITE} state_t;
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;
  localparam int SIGN_BIT = 3;
endpackage

// File: rtl/data_mem_align.sv
// data_mem_align: lane extract/extend for loads and lane merge for stores; unknown sizes act as word.
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);
  logic        is_byte, is_half;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] bmask, hmask;
  always_comb begin
    is_byte  = size == SZ_BYTE;
    is_half  = size == SZ_HALF;
    byte_v   = 8'(word >> {lane, 3'b000});
    half_v   = lane[1] ? word[31:16] : word[15:0];
    bmask    = 32'h0000_00ff << {lane, 3'b000};
    hmask    = lane[1] ? 32'hffff_0000 : 32'h0000_ffff;
    load_val = is_byte ? {{24{sign & byte_v[7]}}, byte_v} :
               is_half ? {{16{sign & half_v[15]}}, half_v} : word;
    merged   = is_byte ? (word & ~bmask) | ({4{wdata[7:0]}} & bmask) :
               is_half ? (word & ~hmask) | ({2{wdata[15:0]}} & hmask) : wdata;
  end
endmodule

// File: rtl/data_mem.sv
// data_mem: RV32I data RAM with byte/half/word access and a stall-raising access FSM.
// Define DATA_MEM_LED_EN to map an 8-bit LED register at LED_ADDR.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic        clk_stall
);
  localparam int IW = $clog2(DEPTH_WORDS);
  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state;
  logic [IW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q, rd_word, load_val, merged;
  logic [3:0]    mask_q;
  logic          is_write, led_hit, led_hit_q, word_sz;
  logic [7:0]    led_q;
  logic          unused_bits;
`ifdef DATA_MEM_LED_EN
  assign led_hit = addr[31:2] == LED_ADDR[31:2];
`else
  assign led_hit = 1'b0;
`endif
  assign unused_bits = ^{addr[31:IW+2], LED_ADDR};
  assign led         = led_q;
  assign word_sz     = mask_q[2:0] != SZ_BYTE && mask_q[2:0] != SZ_HALF;
  data_mem_align u_align (
    .word     (rd_word),
    .lane     (lane_q),
    .size     (mask_q[2:0]),
    .sign     (mask_q[SIGN_BIT]),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );
  // Single synchronous read port: the word is captured on the request edge.
  always_ff @(posedge clk)
    if (state == IDLE) rd_word <= mem[addr[IW+1:2]];
  // The rst gate keeps a reset that lands on the write-back edge from touching RAM.
  always_ff @(posedge clk)
    if (state == WRITE && !rst && !led_hit_q) mem[idx_q] <= merged;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_stall <= 1'b0;
      read_data <= '0;
      led_q     <= '0;
      idx_q     <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      is_write  <= 1'b0;
      led_hit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (memwrite || memread) begin
          state     <= RD_BUF;
          clk_stall <= 1'b1;
          idx_q     <= addr[IW+1:2];
          lane_q    <= addr[1:0];
          wdata_q   <= write_data;
          mask_q    <= sign_mask;
          is_write  <= memwrite;
          led_hit_q <= led_hit;
        end
        RD_BUF: state <= is_write ? WRITE : READ;
        READ: begin
          read_data <= led_hit_q ? {24'b0, led_q} : load_val;
          state     <= IDLE;
          clk_stall <= 1'b0;
        end
        default: begin
          if (led_hit_q && word_sz) led_q <= wdata_q[7:0];
          state     <= IDLE;
          clk_stall <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem (default build, LED feature off).
module tb_data_mem;
  import data_mem_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, write_data = '0, read_data;
  logic        memwrite = 1'b0, memread = 1'b0, clk_stall;
  logic [3:0]  sign_mask = '0;
  logic [7:0]  led;
  int checks = 0, errors = 0, cyc;
  data_mem dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .read_data(read_data), .led(led), .clk_stall(clk_stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        input logic w, input logic r, output int n);
    @(negedge clk);
    addr = a; write_data = d; sign_mask = m; memwrite = w; memread = r;
    @(posedge clk) #1;
    memwrite = 1'b0; memread = 1'b0;
    n = 0;
    while (clk_stall && n < 8) begin
      @(posedge clk) #1;
      n++;
    end
  endtask
  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    access(a, d, m, 1'b1, 1'b0, cyc);
    chk({tag, "_stall"}, 32'(cyc), 32'd2);
  endtask
  task automatic load(input string tag, input logic [31:0] a, input logic [3:0] m, input logic [31:0] exp);
    access(a, 32'h0, m, 1'b0, 1'b1, cyc);
    chk({tag, "_stall"}, 32'(cyc), 32'd2);
    chk(tag, read_data, exp);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(clk_stall), 32'd0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    @(negedge clk) rst = 1'b0;
    store("clr400", 32'h400, 32'h0, {1'b0, SZ_WORD});
    store("sb400", 32'h400, 32'h0000_0aaa, {1'b0, SZ_BYTE});
    load("lw400", 32'h400, {1'b0, SZ_WORD}, 32'h0000_00aa);
    load("lb400", 32'h400, {1'b1, SZ_BYTE}, 32'hffff_ffaa);
    load("lbu400", 32'h400, {1'b0, SZ_BYTE}, 32'h0000_00aa);
    store("clr100", 32'h100, 32'h0, {1'b0, SZ_WORD});
    store("sh100", 32'h100, 32'h0002_aaaa, {1'b0, SZ_HALF});
    load("lh100", 32'h100, {1'b1, SZ_HALF}, 32'hffff_aaaa);
    load("lhu100", 32'h100, {1'b0, SZ_HALF}, 32'h0000_aaaa);
    load("lw100", 32'h100, {1'b0, SZ_WORD}, 32'h0000_aaaa);
    store("sw40", 32'h40, 32'haaaa_aaaa, {1'b0, SZ_WORD});
    load("lw40", 32'h40, {1'b0, SZ_WORD}, 32'haaaa_aaaa);
    store("sb41", 32'h41, 32'h0000_0055, {1'b0, SZ_BYTE});
    load("lw40b", 32'h40, {1'b0, SZ_WORD}, 32'haaaa_55aa);
    load("lb41", 32'h41, {1'b1, SZ_BYTE}, 32'h0000_0055);
    load("lh42", 32'h42, {1'b1, SZ_HALF}, 32'hffff_aaaa);
    load("lhu43", 32'h43, {1'b0, SZ_HALF}, 32'h0000_aaaa);
    load("lw43", 32'h43, {1'b0, SZ_WORD}, 32'haaaa_55aa);
    load("l000", 32'h40, 4'b1000, 32'haaaa_55aa);
    store("s010", 32'h40, 32'h1234_5678, 4'b0010);
    load("lw40c", 32'h40, {1'b0, SZ_WORD}, 32'h1234_5678);
    store("swwrap", 32'h1040, 32'hcafe_f00d, {1'b0, SZ_WORD});
    load("lwwrap", 32'h40, {1'b0, SZ_WORD}, 32'hcafe_f00d);
    access(32'h80, 32'h1122_3344, {1'b0, SZ_WORD}, 1'b1, 1'b1, cyc);
    chk("both_stall", 32'(cyc), 32'd2);
    chk("both_rdata_hold", read_data, 32'hcafe_f00d);
    load("lw80", 32'h80, {1'b0, SZ_WORD}, 32'h1122_3344);
    @(negedge clk);
    addr = 32'h80; write_data = 32'hdead_beef; sign_mask = {1'b0, SZ_WORD}; memwrite = 1'b1;
    @(posedge clk) #1;
    memwrite = 1'b0;
    chk("mid_stall_hi", 32'(clk_stall), 32'd1);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_stall_lo", 32'(clk_stall), 32'd0);
    chk("mid_rdata", read_data, 32'h0);
    @(negedge clk) rst = 1'b0;
    load("lw80b", 32'h80, {1'b0, SZ_WORD}, 32'h1122_3344);
    store("sw2000", 32'h2000, 32'h0000_005a, {1'b0, SZ_WORD});
    chk("led_off", 32'(led), 32'h0);
    load("lw2000", 32'h2000, {1'b0, SZ_WORD}, 32'h0000_005a);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
